// File: rtl/div_share_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-channel divider-sharing arbiter.
package div_share_arbiter_pkg;

   localparam int unsigned FIFO_DEPTH  = 16;
   localparam logic [7:0]  DZ_QUOTIENT = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      CALC,
      WAIT_OUT,
      WRITE
   } state_t;

endpackage

// File: rtl/div_share_arbiter_rr_arb2.sv
// Two-requester round-robin selector: on a tie the channel not served last wins.
module rr_arb2 (
   input  logic [1:0] elig,
   input  logic       last,
   output logic       gnt,
   output logic       any
);

   always_comb begin
      any = |elig;
      if (&elig) begin
         gnt = ~last;
      end else begin
         gnt = elig[1];
      end
   end

endmodule

// File: rtl/div_share_arbiter.sv
// Arbitrates one shared divider between two operand/result FIFO channel pairs.
module div_share_arbiter #(
   parameter int unsigned FIFO_DEPTH = div_share_arbiter_pkg::FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  in_left0,
   input  logic [4:0]  in_left1,
   output logic        rd_req0,
   output logic        rd_req1,
   input  logic [15:0] rd_data0,
   input  logic [15:0] rd_data1,
   output logic        div_start,
   output logic [7:0]  dividend,
   output logic [7:0]  divisor,
   input  logic        div_done,
   input  logic [7:0]  div_q,
   input  logic [7:0]  div_r,
   input  logic [4:0]  out_left0,
   input  logic [4:0]  out_left1,
   output logic        wr_en0,
   output logic        wr_en1,
   output logic [15:0] wr_data,
   output logic        grant,
   output logic        busy,
   output logic        dz_err
);

   import div_share_arbiter_pkg::*;

   localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic        busy_q, busy_d;
   logic        rd_req0_q, rd_req0_d;
   logic        rd_req1_q, rd_req1_d;
   logic        wr_en0_q, wr_en0_d;
   logic        wr_en1_q, wr_en1_d;
   logic        div_start_q, div_start_d;
   logic [7:0]  dividend_q, dividend_d;
   logic [7:0]  divisor_q, divisor_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        dz_err_q, dz_err_d;

   logic [1:0]  elig;
   logic        arb_gnt;
   logic        arb_any;
   logic [15:0] rd_sel;
   logic [4:0]  out_sel;

   assign elig[0] = (in_left0 < DEPTH_L);
   assign elig[1] = (in_left1 < DEPTH_L);

   rr_arb2 u_rr_arb2 (
      .elig (elig),
      .last (last_q),
      .gnt  (arb_gnt),
      .any  (arb_any)
   );

   assign rd_sel  = grant_q ? rd_data1 : rd_data0;
   assign out_sel = grant_q ? out_left1 : out_left0;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      rd_req0_d   = 1'b0;
      rd_req1_d   = 1'b0;
      wr_en0_d    = 1'b0;
      wr_en1_d    = 1'b0;
      dz_err_d    = 1'b0;
      div_start_d = div_start_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      wr_data_d   = wr_data_q;

      // Strobes are set one state early so the registered pulse lands in READ/WRITE.
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d   = READ;
               grant_d   = arb_gnt;
               rd_req0_d = ~arb_gnt;
               rd_req1_d = arb_gnt;
            end
         end
         READ: begin
            state_d = LATCH;
         end
         LATCH: begin
            dividend_d = rd_sel[15:8];
            divisor_d  = rd_sel[7:0];
            if (rd_sel[7:0] != '0) begin
               state_d     = CALC;
               div_start_d = 1'b1;
            end else begin
               state_d   = WAIT_OUT;
               wr_data_d = {DZ_QUOTIENT, rd_sel[15:8]};
               dz_err_d  = 1'b1;
            end
         end
         CALC: begin
            if (div_done) begin
               wr_data_d   = {div_q, div_r};
               div_start_d = 1'b0;
               state_d     = WAIT_OUT;
            end
         end
         WAIT_OUT: begin
            if (out_sel != '0) begin
               state_d  = WRITE;
               wr_en0_d = ~grant_q;
               wr_en1_d = grant_q;
            end
         end
         WRITE: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         busy_q      <= 1'b0;
         rd_req0_q   <= 1'b0;
         rd_req1_q   <= 1'b0;
         wr_en0_q    <= 1'b0;
         wr_en1_q    <= 1'b0;
         div_start_q <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         wr_data_q   <= '0;
         dz_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         rd_req0_q   <= rd_req0_d;
         rd_req1_q   <= rd_req1_d;
         wr_en0_q    <= wr_en0_d;
         wr_en1_q    <= wr_en1_d;
         div_start_q <= div_start_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         wr_data_q   <= wr_data_d;
         dz_err_q    <= dz_err_d;
      end
   end

   assign rd_req0   = rd_req0_q;
   assign rd_req1   = rd_req1_q;
   assign wr_en0    = wr_en0_q;
   assign wr_en1    = wr_en1_q;
   assign div_start = div_start_q;
   assign dividend  = dividend_q;
   assign divisor   = divisor_q;
   assign wr_data   = wr_data_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign dz_err    = dz_err_q;

endmodule
